cache_fill_arbiter: RTL and testbench

- Shares the single multi-cycle main memory between the instruction-cache miss path, the data-cache miss path and write-through stores from the MEM stage.
- Grants one requester at a time and sequences an 8-word block fill as a pipelined burst.
- Steers returned words into the selected cache and pulses a per-requester done signal.
- Sits between both caches and the memory model; busy feeds the pipeline stall logic.

---
 rtl/cache_fill_arbiter.sv | 105 ++++++++++
 tb/tb_cache_fill_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares main memory between I/D cache block fills and write-through stores.
module cache_fill_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_miss_req,
    input  logic [ADDR_W-1:0]          i_miss_addr,
    input  logic                       d_miss_req,
    input  logic [ADDR_W-1:0]          d_miss_addr,
    input  logic                       d_wr_req,
    input  logic [ADDR_W-1:0]          d_wr_addr,
    input  logic [DATA_W-1:0]          d_wr_data,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_rvalid,
    output logic [DATA_W-1:0]          fill_data,
    output logic [$clog2(WORDS)-1:0]   fill_word,
    output logic                       fill_i_we,
    output logic                       fill_d_we,
    output logic                       i_fill_done,
    output logic                       d_fill_done,
    output logic                       d_wr_ack,
    output logic                       busy
);
    localparam int CW = $clog2(WORDS);
    localparam int WB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(WORDS * WB - 1);

    typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

    state_t            state, state_nx;
    logic [CW:0]       issue_cnt;
    logic [CW-1:0]     rx_cnt;
    logic              tgt_d;
    logic              last_d;
    logic [ADDR_W-1:0] base;
    logic              grant_d;
    logic              take_miss;
    logic              issuing;
    logic              rx;
    logic              rx_last;

    // Round-robin between misses: D wins a tie unless it was served last.
    assign grant_d   = d_miss_req && (!i_miss_req || !last_d);
    assign take_miss = state == IDLE && !d_wr_req && (i_miss_req || d_miss_req);
    assign issuing   = state == FILL && issue_cnt < (CW+1)'(WORDS);
    assign rx        = state == FILL && mem_rvalid;
    assign rx_last   = rx && rx_cnt == CW'(WORDS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rx_cnt    <= '0;
            tgt_d     <= 1'b0;
            last_d    <= 1'b0;
            base      <= '0;
        end else begin
            state <= state_nx;
            if (take_miss) begin
                tgt_d <= grant_d;
                base  <= (grant_d ? d_miss_addr : i_miss_addr) & ~BLK_MASK;
            end
            if (issuing)
                issue_cnt <= issue_cnt + 1'b1;
            if (rx)
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_last)
                last_d <= tgt_d;
            if (state == DONE) begin
                issue_cnt <= '0;
                rx_cnt    <= '0;
            end
        end
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = d_wr_req ? WRITE : take_miss ? FILL : IDLE;
            FILL:    state_nx = rx_last ? DONE : FILL;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_en      = state == WRITE || issuing;
    assign mem_wr      = state == WRITE;
    assign mem_addr    = state == WRITE ? d_wr_addr
                       : issuing ? base + ADDR_W'(issue_cnt) * ADDR_W'(WB) : '0;
    assign mem_wdata   = state == WRITE ? d_wr_data : '0;
    assign d_wr_ack    = state == WRITE;
    assign fill_data   = rx ? mem_rdata : '0;
    assign fill_word   = rx ? rx_cnt : '0;
    assign fill_i_we   = rx && !tgt_d;
    assign fill_d_we   = rx && tgt_d;
    assign i_fill_done = state == DONE && !tgt_d;
    assign d_fill_done = state == DONE && tgt_d;
    assign busy        = state != IDLE;
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: directed checks of grant order, burst timing, write-through and reset abort.
module tb_cache_fill_arbiter;
    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss_req = 1'b0, d_miss_req = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_i_we, fill_d_we, i_fill_done, d_fill_done, d_wr_ack, busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit gaps = 1'b0;
    bit spur = 1'b0;
    int          qt[$];
    logic [15:0] qd[$];

    cache_fill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
        .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_data(fill_data), .fill_word(fill_word),
        .fill_i_we(fill_i_we), .fill_d_we(fill_d_we),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .d_wr_ack(d_wr_ack), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Memory returns 0xA000 + word index, in order, MEM_LAT cycles after issue (later when gapped).
    always @(negedge clk) begin
        if (mem_en && !mem_wr) begin
            qt.push_back(cyc + MEM_LAT);
            qd.push_back(16'hA000 + 16'(mem_addr[3:1]));
        end
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (spur) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'h5555;
        end else if (qt.size() > 0 && qt[0] <= cyc && (!gaps || $urandom_range(0, 1) == 1)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = qd[0];
            void'(qt.pop_front());
            void'(qd.pop_front());
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic watch_fill(input bit tgt, input logic [15:0] base,
                              output int first_we, output int last_we, output int done_cyc);
        int nrx  = 0;
        int niss = 0;
        first_we = -1;
        last_we  = -1;
        done_cyc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (mem_en) begin
                check("rd_not_wr", 32'(mem_wr), 0);
                check("rd_addr", 32'(mem_addr), 32'(base + 16'(2 * niss)));
                niss++;
            end
            if (fill_i_we || fill_d_we) begin
                check("we_sel", 32'({fill_i_we, fill_d_we}), tgt ? 2'b01 : 2'b10);
                check("fill_word", 32'(fill_word), nrx);
                check("fill_data", 32'(fill_data), 32'(16'hA000 + 16'(nrx)));
                if (nrx == 0) first_we = cyc;
                last_we = cyc;
                nrx++;
            end
            if (i_fill_done || d_fill_done) begin
                check("done_sel", 32'({i_fill_done, d_fill_done}), tgt ? 2'b01 : 2'b10);
                check("rx_count", nrx, 8);
                check("rd_count", niss, 8);
                done_cyc = cyc;
                return;
            end
        end
        check("fill_timeout", 0, 1);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 32'({mem_en, mem_wr, busy, fill_i_we, fill_d_we, i_fill_done, d_fill_done, d_wr_ack}), 0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_data"}, 32'({fill_data, 13'd0, fill_word}), 0);
    endtask

    initial begin
        int n, fw, lw, dc, cnt;
        repeat (2) @(negedge clk);
        #1 check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single I miss: exact burst timing.
        @(negedge clk);
        i_miss_addr = 16'h123A;
        i_miss_req  = 1'b1;
        n = cyc;
        watch_fill(1'b0, 16'h1230, fw, lw, dc);
        i_miss_req = 1'b0;
        check("first_we_cyc", fw, n + 5);
        check("last_we_cyc", lw, n + 12);
        check("done_cyc", dc, n + 13);
        @(negedge clk); #1;
        check("idle_after_fill", 32'(busy), 0);

        // Simultaneous misses: D first after reset, then I despite D still requesting.
        @(negedge clk);
        i_miss_addr = 16'h2000;
        d_miss_addr = 16'h3456;
        i_miss_req  = 1'b1;
        d_miss_req  = 1'b1;
        watch_fill(1'b1, 16'h3450, fw, lw, dc);
        watch_fill(1'b0, 16'h2000, fw, lw, dc);
        i_miss_req = 1'b0;
        d_miss_req = 1'b0;
        @(negedge clk);

        // Store outranks a pending miss.
        @(negedge clk);
        d_wr_addr   = 16'h0040;
        d_wr_data   = 16'hBEEF;
        d_wr_req    = 1'b1;
        d_miss_addr = 16'h0048;
        d_miss_req  = 1'b1;
        @(negedge clk); #1;
        check("wr_en_wr", 32'({mem_en, mem_wr, d_wr_ack, busy}), 4'b1111);
        check("wr_addr", 32'(mem_addr), 16'h0040);
        check("wr_data", 32'(mem_wdata), 16'hBEEF);
        d_wr_req = 1'b0;
        @(negedge clk); #1;
        check("wr_ack_pulse", 32'(d_wr_ack), 0);
        watch_fill(1'b1, 16'h0040, fw, lw, dc);
        d_miss_req = 1'b0;
        @(negedge clk);

        // Gapped returns, then spurious rvalid while idle.
        gaps = 1'b1;
        @(negedge clk);
        i_miss_addr = 16'h5678;
        i_miss_req  = 1'b1;
        watch_fill(1'b0, 16'h5670, fw, lw, dc);
        i_miss_req = 1'b0;
        gaps = 1'b0;
        @(negedge clk); #1;
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("spur_we", 32'({fill_i_we, fill_d_we, busy}), 0);
        end
        spur = 1'b0;
        @(negedge clk);

        // Reset after the third returned word, then a full refetch.
        i_miss_addr = 16'h4000;
        i_miss_req  = 1'b1;
        cnt = 0;
        for (int k = 0; k < 50 && cnt < 3; k++) begin
            @(negedge clk); #1;
            if (fill_i_we) cnt++;
        end
        check("pre_abort_words", cnt, 3);
        rst_n = 1'b0;
        #1 check_quiet("abort");
        qt.delete();
        qd.delete();
        @(negedge clk);
        rst_n = 1'b1;
        watch_fill(1'b0, 16'h4000, fw, lw, dc);
        i_miss_req = 1'b0;
        @(negedge clk); #1;
        check("idle_end", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
